// File: rtl/key_scan_ctrl.sv
// Keypad scan controller: drives two active-low columns, debounces three rows and
// buffers one key event at a time behind a valid/ready handshake.
module key_scan_ctrl #(
  parameter int SCAN_DIV     = 16,
  parameter int DEBOUNCE_CNT = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       key_row2,
  input  logic       key_row3,
  input  logic       key_row4,
  output logic       key_col1,
  output logic       key_col2,
  output logic       key_valid,
  output logic [2:0] key_code,
  input  logic       key_ready,
  output logic       key_overrun
);

  localparam int            PW          = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_LAST  = PW'(SCAN_DIV - 1);
  localparam logic [3:0]    CNT_LAST    = 4'(DEBOUNCE_CNT - 1);
  localparam logic          SINGLE_TICK = (DEBOUNCE_CNT == 1) ? 1'b1 : 1'b0;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN1 = 3'd1,
    SCAN2 = 3'd2,
    DEB   = 3'd3,
    REL   = 3'd4
  } state_t;

  state_t        state_r;
  logic [2:0]    row_meta_r;
  logic [2:0]    rows_r;
  logic [PW-1:0] presc_r;
  logic [2:0]    pat_r;
  logic [2:0]    code_r;
  logic [3:0]    deb_cnt_r;
  logic [3:0]    rel_cnt_r;

  logic          tick_s;
  logic          all_high_s;
  logic          one_low_s;
  logic [2:0]    row_base_s;
  logic [2:0]    scan_code_s;
  logic          emit_s;
  logic [2:0]    emit_code_s;

  // Two-flop synchronizer; rows_r is {row2,row3,row4}.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      row_meta_r <= 3'b111;
      rows_r     <= 3'b111;
    end else begin
      row_meta_r <= {key_row2, key_row3, key_row4};
      rows_r     <= row_meta_r;
    end
  end

  // Scan-rate prescaler.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      presc_r <= {PW{1'b0}};
    end else if (tick_s) begin
      presc_r <= {PW{1'b0}};
    end else begin
      presc_r <= presc_r + PW'(1);
    end
  end

  assign tick_s      = (presc_r == PRESC_LAST);
  assign all_high_s  = (rows_r == 3'b111);
  assign scan_code_s = row_base_s + {2'b00, (state_r == SCAN2)};

  // Decode a single low row into its code base (2*(row-2)).
  always_comb begin
    one_low_s  = 1'b0;
    row_base_s = 3'd0;
    case (rows_r)
      3'b011:  begin one_low_s = 1'b1; row_base_s = 3'd0; end
      3'b101:  begin one_low_s = 1'b1; row_base_s = 3'd2; end
      3'b110:  begin one_low_s = 1'b1; row_base_s = 3'd4; end
      default: begin one_low_s = 1'b0; row_base_s = 3'd0; end
    endcase
  end

  // Event strobe: fires on the tick where the debounce count is reached.
  always_comb begin
    emit_s      = 1'b0;
    emit_code_s = code_r;
    if (tick_s) begin
      case (state_r)
        SCAN1, SCAN2: begin
          emit_s      = one_low_s & SINGLE_TICK;
          emit_code_s = scan_code_s;
        end
        DEB: begin
          emit_s      = (rows_r == pat_r) && (deb_cnt_r == CNT_LAST);
          emit_code_s = code_r;
        end
        default: begin
          emit_s      = 1'b0;
          emit_code_s = code_r;
        end
      endcase
    end else begin
      emit_s      = 1'b0;
      emit_code_s = code_r;
    end
  end

  // Scan/debounce FSM with registered column drive.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_r   <= IDLE;
      key_col1  <= 1'b0;
      key_col2  <= 1'b0;
      pat_r     <= 3'b111;
      code_r    <= 3'd0;
      deb_cnt_r <= 4'd0;
      rel_cnt_r <= 4'd0;
    end else if (tick_s) begin
      case (state_r)
        IDLE: begin
          if (!all_high_s) begin
            state_r  <= SCAN1;
            key_col1 <= 1'b0;
            key_col2 <= 1'b1;
          end
        end
        SCAN1, SCAN2: begin
          if (all_high_s) begin
            if (state_r == SCAN1) begin
              state_r  <= SCAN2;
              key_col1 <= 1'b1;
              key_col2 <= 1'b0;
            end else begin
              state_r  <= IDLE;
              key_col1 <= 1'b0;
              key_col2 <= 1'b0;
            end
          end else if (one_low_s) begin
            pat_r     <= rows_r;
            code_r    <= scan_code_s;
            deb_cnt_r <= 4'd1;
            rel_cnt_r <= 4'd0;
            state_r   <= SINGLE_TICK ? REL : DEB;
          end else begin
            // Ghosting risk with several rows low: wait for full release instead.
            rel_cnt_r <= 4'd0;
            state_r   <= REL;
          end
        end
        DEB: begin
          if (rows_r == pat_r) begin
            if (deb_cnt_r == CNT_LAST) begin
              rel_cnt_r <= 4'd0;
              state_r   <= REL;
            end else begin
              deb_cnt_r <= deb_cnt_r + 4'd1;
            end
          end else begin
            state_r  <= IDLE;
            key_col1 <= 1'b0;
            key_col2 <= 1'b0;
          end
        end
        REL: begin
          if (!all_high_s) begin
            rel_cnt_r <= 4'd0;
          end else if (rel_cnt_r == CNT_LAST) begin
            rel_cnt_r <= 4'd0;
            state_r   <= IDLE;
            key_col1  <= 1'b0;
            key_col2  <= 1'b0;
          end else begin
            rel_cnt_r <= rel_cnt_r + 4'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          key_col1 <= 1'b0;
          key_col2 <= 1'b0;
        end
      endcase
    end
  end

  // One-deep event buffer; a drain in the emit cycle frees the slot for the new code.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      key_valid   <= 1'b0;
      key_code    <= 3'd0;
      key_overrun <= 1'b0;
    end else if (emit_s) begin
      if (!key_valid || key_ready) begin
        key_valid <= 1'b1;
        key_code  <= emit_code_s;
      end else begin
        key_overrun <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_key_scan_ctrl.sv
// Directed bench for key_scan_ctrl (SCAN_DIV=4, DEBOUNCE_CNT=3) with a keypad matrix model.
module tb_key_scan_ctrl;

  logic       clk = 1'b0;
  logic       resetn;
  logic       key_row2, key_row3, key_row4;
  logic       key_col1, key_col2;
  logic       key_valid;
  logic [2:0] key_code;
  logic       key_ready;
  logic       key_overrun;

  logic [5:0] keys;          // bit n = key with code n held down
  logic [1:0] tb_presc;
  logic       valid_q;
  int         ev_cnt;
  int         xfer_cnt;
  logic [2:0] last_xfer;
  int         checks;
  int         failures;

  key_scan_ctrl #(.SCAN_DIV(4), .DEBOUNCE_CNT(3)) dut (
    .clk(clk), .resetn(resetn),
    .key_row2(key_row2), .key_row3(key_row3), .key_row4(key_row4),
    .key_col1(key_col1), .key_col2(key_col2),
    .key_valid(key_valid), .key_code(key_code),
    .key_ready(key_ready), .key_overrun(key_overrun)
  );

  always #5 clk = ~clk;

  // Keypad matrix: a row is pulled low by a held key whose column is driven low.
  assign key_row2 = ~((keys[0] & ~key_col1) | (keys[1] & ~key_col2));
  assign key_row3 = ~((keys[2] & ~key_col1) | (keys[3] & ~key_col2));
  assign key_row4 = ~((keys[4] & ~key_col1) | (keys[5] & ~key_col2));

  // Scan-tick phase reference and event/transfer monitor.
  always @(posedge clk) begin
    if (!resetn) tb_presc <= 2'd0;
    else         tb_presc <= tb_presc + 2'd1;
    if (key_valid && !valid_q) ev_cnt <= ev_cnt + 1;
    if (key_valid && key_ready) begin
      xfer_cnt  <= xfer_cnt + 1;
      last_xfer <= key_code;
    end
    valid_q <= key_valid;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Leaves the bench 1 time unit after a tick edge (prescaler just wrapped to 0).
  task automatic align();
    do step(1); while (tb_presc != 2'd0);
  endtask

  task automatic drain();
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    keys   = 6'd0;
    step(2);
    checks++; if ({key_col1, key_col2} !== 2'b00) begin failures++; $display("FAIL reset_cols: got %b expected 00", {key_col1, key_col2}); end
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b expected 0", key_valid); end
    checks++; if (key_code !== 3'd0) begin failures++; $display("FAIL reset_code: got %0d expected 0", key_code); end
    checks++; if (key_overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b expected 0", key_overrun); end
    resetn = 1'b1;
    step(2);
  endtask

  task automatic test_clean_press();
    int ev0;
    ev0 = ev_cnt;
    align();
    keys = 6'b100000;
    step(19);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL clean_early: got valid=%b expected 0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1) begin failures++; $display("FAIL clean_latency: got valid=%b expected 1", key_valid); end
    checks++; if (key_code !== 3'd5) begin failures++; $display("FAIL clean_code: got %0d expected 5", key_code); end
    step(120);
    checks++; if (key_valid !== 1'b1 || key_code !== 3'd5) begin failures++; $display("FAIL clean_hold: got valid=%b code=%0d expected 1/5", key_valid, key_code); end
    keys = 6'd0;
    step(32);
    checks++; if ({key_col1, key_col2} !== 2'b00) begin failures++; $display("FAIL clean_idle_cols: got %b expected 00", {key_col1, key_col2}); end
    drain();
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL clean_drain: got valid=%b expected 0", key_valid); end
    checks++; if (last_xfer !== 3'd5) begin failures++; $display("FAIL clean_xfer: got %0d expected 5", last_xfer); end
    step(40);
    checks++; if (ev_cnt !== ev0 + 1 || key_valid !== 1'b0) begin failures++; $display("FAIL clean_single: got events=%0d valid=%b expected %0d/0", ev_cnt - ev0, key_valid, 1); end
    checks++; if (key_overrun !== 1'b0) begin failures++; $display("FAIL clean_overrun: got %b expected 0", key_overrun); end
  endtask

  task automatic test_bounce();
    int ev0;
    ev0 = ev_cnt;
    keys = 6'b000001; step(8);
    keys = 6'd0;      step(4);
    keys = 6'b000001; step(40);
    keys = 6'd0;      step(32);
    checks++; if (key_valid !== 1'b1 || key_code !== 3'd0) begin failures++; $display("FAIL bounce_event: got valid=%b code=%0d expected 1/0", key_valid, key_code); end
    checks++; if (ev_cnt !== ev0 + 1) begin failures++; $display("FAIL bounce_count: got %0d events expected 1", ev_cnt - ev0); end
    drain();
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL bounce_drain: got valid=%b expected 0", key_valid); end
  endtask

  task automatic test_glitch();
    int ev0;
    ev0 = ev_cnt;
    keys = 6'b000001; step(8);
    keys = 6'd0;      step(24);
    checks++; if (ev_cnt !== ev0 || key_valid !== 1'b0) begin failures++; $display("FAIL glitch_event: got events=%0d valid=%b expected 0/0", ev_cnt - ev0, key_valid); end
    checks++; if ({key_col1, key_col2} !== 2'b00) begin failures++; $display("FAIL glitch_idle: got cols=%b expected 00", {key_col1, key_col2}); end
  endtask

  task automatic test_overrun();
    keys = 6'b000100; step(32);
    keys = 6'd0;      step(32);
    keys = 6'b001000; step(40);
    keys = 6'd0;      step(32);
    checks++; if (key_valid !== 1'b1 || key_code !== 3'd2) begin failures++; $display("FAIL overrun_code: got valid=%b code=%0d expected 1/2", key_valid, key_code); end
    checks++; if (key_overrun !== 1'b1) begin failures++; $display("FAIL overrun_flag: got %b expected 1", key_overrun); end
    drain();
    checks++; if (key_valid !== 1'b0 || key_code !== 3'd2) begin failures++; $display("FAIL overrun_drain: got valid=%b code=%0d expected 0/2", key_valid, key_code); end
    checks++; if (last_xfer !== 3'd2 || key_overrun !== 1'b1) begin failures++; $display("FAIL overrun_xfer: got xfer=%0d ovr=%b expected 2/1", last_xfer, key_overrun); end
  endtask

  task automatic test_load_and_drain();
    resetn = 1'b0; step(1);
    resetn = 1'b1; step(2);
    keys = 6'b010000; step(32);
    keys = 6'd0;      step(32);
    checks++; if (key_valid !== 1'b1 || key_code !== 3'd4) begin failures++; $display("FAIL lad_first: got valid=%b code=%0d expected 1/4", key_valid, key_code); end
    align();
    keys = 6'b000010;
    step(19);
    key_ready = 1'b1;
    step(1);
    key_ready = 1'b0;
    checks++; if (key_valid !== 1'b1 || key_code !== 3'd1) begin failures++; $display("FAIL lad_reload: got valid=%b code=%0d expected 1/1", key_valid, key_code); end
    checks++; if (last_xfer !== 3'd4) begin failures++; $display("FAIL lad_xfer: got %0d expected 4", last_xfer); end
    checks++; if (key_overrun !== 1'b0) begin failures++; $display("FAIL lad_overrun: got %b expected 0", key_overrun); end
    keys = 6'd0; step(32);
    drain();
    checks++; if (key_valid !== 1'b0 || last_xfer !== 3'd1) begin failures++; $display("FAIL lad_drain: got valid=%b xfer=%0d expected 0/1", key_valid, last_xfer); end
  endtask

  task automatic test_multi_key();
    int ev0;
    ev0 = ev_cnt;
    keys = 6'b000101; step(32);
    checks++; if ({key_col1, key_col2} !== 2'b01) begin failures++; $display("FAIL multi_rel_cols: got %b expected 01", {key_col1, key_col2}); end
    align();
    keys = 6'd0;
    step(11);
    checks++; if ({key_col1, key_col2} !== 2'b01) begin failures++; $display("FAIL multi_rel_hold: got %b expected 01", {key_col1, key_col2}); end
    step(1);
    checks++; if ({key_col1, key_col2} !== 2'b00) begin failures++; $display("FAIL multi_idle: got %b expected 00", {key_col1, key_col2}); end
    checks++; if (ev_cnt !== ev0 || key_valid !== 1'b0) begin failures++; $display("FAIL multi_event: got events=%0d valid=%b expected 0/0", ev_cnt - ev0, key_valid); end
  endtask

  task automatic test_reset_mid();
    keys = 6'b100000; step(40);
    keys = 6'd0;      step(32);
    keys = 6'b000001; step(32);
    keys = 6'd0;      step(32);
    checks++; if (key_valid !== 1'b1 || key_overrun !== 1'b1) begin failures++; $display("FAIL rmid_setup: got valid=%b ovr=%b expected 1/1", key_valid, key_overrun); end
    align();
    keys = 6'b000100;
    step(9);
    checks++; if ({key_col1, key_col2} !== 2'b01) begin failures++; $display("FAIL rmid_deb_cols: got %b expected 01", {key_col1, key_col2}); end
    resetn = 1'b0;
    keys   = 6'd0;
    step(1);
    checks++; if ({key_col1, key_col2, key_valid, key_code, key_overrun} !== 7'd0) begin failures++; $display("FAIL rmid_reset: got cols=%b valid=%b code=%0d ovr=%b expected all 0", {key_col1, key_col2}, key_valid, key_code, key_overrun); end
    resetn = 1'b1;
    step(40);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rmid_no_event: got valid=%b expected 0", key_valid); end
    align();
    keys = 6'b001000;
    step(19);
    checks++; if (key_valid !== 1'b0) begin failures++; $display("FAIL rmid_early: got valid=%b expected 0", key_valid); end
    step(1);
    checks++; if (key_valid !== 1'b1 || key_code !== 3'd3) begin failures++; $display("FAIL rmid_press: got valid=%b code=%0d expected 1/3", key_valid, key_code); end
    keys = 6'd0; step(32);
    drain();
    checks++; if (key_valid !== 1'b0 || key_overrun !== 1'b0) begin failures++; $display("FAIL rmid_drain: got valid=%b ovr=%b expected 0/0", key_valid, key_overrun); end
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    ev_cnt    = 0;
    xfer_cnt  = 0;
    last_xfer = 3'd0;
    valid_q   = 1'b0;
    keys      = 6'd0;
    key_ready = 1'b0;
    resetn    = 1'b0;
    step(2);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_overrun();
    test_load_and_drain();
    test_multi_key();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key_scan_ctrl.md
# key_scan_ctrl

Keypad scan controller for the digital watch. It drives the two active-low columns of the 2×3 keypad region (col1/col2 × row2–row4) and synchronizes and debounces the rows. Each completed press becomes exactly one key event, held in a one-deep buffer with a valid/ready handshake. It replaces ad-hoc per-digit scan decoding in the watch: the time-setting logic consumes `key_code` events instead of sampling raw rows.

## Interface
Parameters:
- `SCAN_DIV`, default 16: clk cycles per scan tick; legal range ≥ 4.
- `DEBOUNCE_CNT`, default 4: consecutive matching ticks needed to accept a press or a release; legal range 1–15.

Ports:
- `clk`, input, 1: single clock; all logic on posedge.
- `resetn`, input, 1: reset, synchronous, active-low.
- `key_row2`, `key_row3`, `key_row4`, input, 1 each: raw keypad rows, active-low, asynchronous to `clk`.
- `key_col1`, `key_col2`, output, 1 each: column drives; 0 = column selected.
- `key_valid`, output, 1: buffered event present.
- `key_code`, output, 3: event code, valid while `key_valid`=1.
- `key_ready`, input, 1: consumer accepts the event; transfer occurs on any cycle with `key_valid & key_ready`.
- `key_overrun`, output, 1: sticky flag; an event was dropped because the buffer was full.

## Operation
- **Row synchronizer:** each row passes through 2 flops (reset value 1). `rows[2:0]` = {row2,row3,row4} after synchronization. All decisions use `rows` only.
- **Prescaler:** counts 0..SCAN_DIV-1 and wraps. `tick` = (count == SCAN_DIV-1). The FSM and the debounce counters update only on `tick`.
- **Key codes:** code = 2·(row−2) + (col−1).
  - row2: col1=0, col2=1.
  - row3: col1=2, col2=3.
  - row4: col1=4, col2=5.
  - Codes 6 and 7 are never emitted.
- **FSM states and column drive ({col1,col2}):**
  - IDLE (00): on tick, if rows≠111 → SCAN1.
  - SCAN1 (01): on tick:
    - rows==111 → SCAN2.
    - exactly one row low → latch pattern and col=1, deb_cnt=1, → DEB.
    - more than one row low → REL.
  - SCAN2 (10): on tick:
    - rows==111 → IDLE (spurious wake).
    - exactly one row low → latch pattern and col=2, deb_cnt=1, → DEB.
    - more than one row low → REL.
  - DEB (column held as latched): on tick:
    - rows == latched pattern → deb_cnt+1.
    - otherwise → IDLE with no event.
    - When deb_cnt reaches DEBOUNCE_CNT (including immediately on entry when DEBOUNCE_CNT=1) → emit event, → REL.
  - REL (column held): on tick:
    - rows==111 → rel_cnt+1.
    - otherwise → rel_cnt=0.
    - rel_cnt reaching DEBOUNCE_CNT → IDLE.
    - rel_cnt clears on entry to REL.
- **Event buffer:**
  - On emit: if the buffer is empty, or is being drained this same cycle (`key_valid & key_ready`), load `key_code` and set `key_valid`=1.
  - Otherwise drop the event and set `key_overrun`=1.
  - A transfer with no simultaneous load clears `key_valid`.
  - `key_code` holds its last value when not valid.
- **Overrun flag:** `key_overrun` clears only on reset.
- **Single event per hold:** a held key produces exactly one event regardless of hold length. A second key pressed while in REL is ignored.

## Timing
- **Reset values (cycle after `resetn`=0 sampled):**
  - state=IDLE, `{key_col1,key_col2}`=00, `key_valid`=0, `key_code`=0, `key_overrun`=0.
  - prescaler=0, synchronizers=111, deb_cnt=rel_cnt=0.
- **Reset mid-operation** (DEB, REL, or pending event) discards everything. No event survives reset.
- **All outputs are registered.**
- **Column change timing:** the column drive changes the cycle after a tick. SCAN_DIV ≥ 4 guarantees rows have settled through the synchronizer before the next tick.
- **Press latency:** let T0 be the tick at which IDLE sees rows≠111.
  - col1 key: emit at tick T0+DEBOUNCE_CNT.
  - col2 key: emit at tick T0+DEBOUNCE_CNT+1.
  - `key_valid` rises the cycle after the emit tick.
- **Handshake:** `key_valid` falls the cycle after transfer, unless a load occurs in the same cycle. A load in the transfer cycle keeps `key_valid`=1 with the new code.

## Test plan
Settings for all scenarios: SCAN_DIV=4, DEBOUNCE_CNT=3.

1. **Clean press, col2×row4.** Hold row4 low while col2=0 for 30 ticks, `key_ready`=0 → exactly one event: `key_valid`=1, `key_code`=5, held until `key_ready`=1 for one cycle. Then `key_valid`=0, no second event.
2. **Bounce.**
   - row2/col1 low for 2 ticks, high for 1, then low for 10 → exactly one event, code=0.
   - A 2-tick glitch alone → no event; FSM returns to IDLE.
3. **Overrun.**
   - Press and release code 2, then press code 3, with `key_ready`=0 → `key_code` stays 2, `key_overrun`=1.
   - Then `key_ready`=1 → code 2 transferred, `key_valid`=0.
4. **Simultaneous load and drain.** Assert `key_ready` in exactly the cycle the second event (code 1) is emitted, with code 4 pending → code 4 transferred, `key_valid` stays 1, `key_code`=1, `key_overrun`=0.
5. **Multi-key.** row2 and row3 both low on col1 → no event. FSM stays in REL until rows=111 for 3 ticks, then returns to IDLE with cols=00.
6. **Reset mid-debounce.** Assert `resetn`=0 for 1 cycle while in DEB, with `key_valid`=1 and `key_overrun`=1 → next cycle all outputs at reset values. A subsequent clean press yields a normal event.
